pwr_transition_counter: RTL and testbench
=========================================

Name: pwr_transition_counter

Overview:
Synthesis-side consumer of the mapped cell netlist: counts 0->1 transitions on up to N_PROBES flop outputs (DFF/DFFSR Q nets) of the design under test.
Replaces ad-hoc hierarchical counter increments with a self-contained, synthesizable block.
Provides per-probe saturating counters, a saturating grand total, and a 4-phase read handshake for the testbench or probador to fetch counts for the power estimate.

Parameters:
N_PROBES, 8, number of monitored nets
CNT_W, 16, width of each per-probe counter
IDX_W, 3, width of read index; must satisfy 2**IDX_W >= N_PROBES
TOT_W, 19, width of total counter (CNT_W+IDX_W)

Ports:
clk  in  1  single clock, rising-edge active
reset_L  in  1  asynchronous active-low reset
enable  in  1  counting enabled when 1
clear  in  1  synchronous clear of all counters, total and sat_flag
probe  in  N_PROBES  monitored nets; treated as asynchronous to counting logic only through one sampling flop
rd_req  in  1  read request, 4-phase
rd_idx  in  IDX_W  probe index to read, sampled with rd_req
rd_ack  out  1  read acknowledge
rd_data  out  CNT_W  captured counter value
total_cnt  out  TOT_W  saturating sum of all counted edges
sat_flag  out  1  sticky: some per-probe counter or total saturated

Behaviour:
- Reset (reset_L=0, async): all counters, total_cnt, rd_data, rd_ack and sat_flag are 0. Sample regs probe_q/probe_prev are 0. primed=0. FSM is IDLE. Reset mid-read aborts the read; rd_ack drops immediately.
- Sampling: probe_q<=probe every cycle; probe_prev<=probe_q. Edge vector edge=probe_q & ~probe_prev & {N{primed}}.
- primed is set 1 on the first clk with enable=1 and cleared when enable=0. Result: no spurious edge in the first enabled cycle after reset or re-enable.
- Latency: probe rising at cycle t is reflected in its counter after cycle t+2; counters are registered.
- Count: for each i with edge[i]=1 and enable=1, cnt[i]<=cnt[i]+1, saturating at 2**CNT_W-1. The increment that would overflow sets sat_flag.
- Total: total_cnt<=total_cnt+popcount(edge), saturating at 2**TOT_W-1 and setting sat_flag on clamp. Popcount is combinational, width IDX_W+1.
- clear=1: all counters, total_cnt and sat_flag are 0 next cycle. clear has priority over a simultaneous increment; that cycle's edges are lost. probe_q/probe_prev and primed are unaffected.
- enable=0: counters hold; sampling continues.
- Read FSM:
  - IDLE: rd_ack=0. On rd_req=1 go to CAPTURE.
  - CAPTURE: rd_data<=cnt[rd_idx], or 0 if rd_idx>=N_PROBES. Go to ACK.
  - ACK: rd_ack=1 and rd_data held stable. Stay while rd_req=1. On rd_req=0 go to IDLE, and rd_ack falls the same cycle it goes 0.
  - Latency: rd_req rise -> rd_ack rise = 2 cycles.
  - Captured value reflects the counter at the CAPTURE edge, including that cycle's increment not yet applied. A clear during ACK does not alter rd_data.
- rd_idx is sampled only in CAPTURE; changes elsewhere are ignored.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=2'b00, CAPTURE=2'b01, ACK=2'b10) and a popcount function. No other typedefs.
- One sub-module, sat_counter (params W; ports clk, reset_L, clr, inc, cnt, ovf), instantiated N_PROBES times.
- The total counter is inline, because it adds a multi-bit value.

Test Plan:
1. Reset then enable=1, probe[0] toggles 0->1->0 five times -> after settling, read idx 0: rd_ack 2 cycles after rd_req, rd_data=5, total_cnt=5.
2. probe held at 8'hFF through reset release and enable -> no edges counted; all counters 0, total_cnt=0 (primed check).
3. All 8 probes toggle together 10 times -> each cnt=10, total_cnt=80. Read idx 7 returns 10; read idx 5 with N_PROBES=5 returns 0.
4. CNT_W=4 build, probe[2] gets 17 rising edges -> cnt[2]=15, sat_flag=1, total_cnt=17. Then clear=1 coincident with an edge -> cnt[2]=0, total=0, sat_flag=0.
5. Start read of idx 1 (value 3), assert clear while in ACK -> rd_data stays 3 until rd_req drops; subsequent read returns 0.
6. reset_L pulsed low while in ACK -> rd_ack and rd_data 0 immediately, FSM IDLE; new read after release completes normally.

Source files
------------

// File: rtl/pwr_transition_counter_pkg.sv
// Shared read-FSM encodings and the edge popcount helper for the
// transition counter slice.
package pwr_transition_counter_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] CAPTURE = 2'b01;
  localparam logic [1:0] ACK     = 2'b10;

  // Wide enough for any probe count the block is built with (up to 64).
  function automatic logic [7:0] popcount(input logic [63:0] vec);
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < 64; i++) sum = sum + {7'b0, vec[i]};
    return sum;
  endfunction

endpackage

// File: rtl/pwr_transition_counter_if.sv
// Four-phase read port used to fetch one per-probe transition count.
interface pwr_transition_counter_if #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 3
);
  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, rd_idx, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_idx, output rd_ack, rd_data);
endinterface

// File: rtl/pwr_transition_counter_sat_counter.sv
// Saturating up-counter; ovf flags an increment that is dropped at the ceiling.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  assign ovf = inc && !clr && (cnt == {W{1'b1}});

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)          cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (inc && !ovf)  cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pwr_transition_counter.sv
// Counts rising edges on monitored flop outputs with per-probe and total
// saturating counters, readable through a four-phase handshake.
module pwr_transition_counter
  import pwr_transition_counter_pkg::*;
#(
  parameter int N_PROBES = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = 3,
  parameter int TOT_W    = 19
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [N_PROBES-1:0]   probe,
  pwr_transition_counter_if.slave rd,
  output logic [TOT_W-1:0]      total_cnt,
  output logic                  sat_flag
);

  logic [N_PROBES-1:0] probe_q;
  logic [N_PROBES-1:0] probe_prev;
  logic [N_PROBES-1:0] edge_vec;
  logic [N_PROBES-1:0] cnt_ovf;
  logic                primed;
  logic [CNT_W-1:0]    cnt [N_PROBES];
  logic [IDX_W:0]      edge_cnt;
  logic [TOT_W:0]      total_sum;
  logic [CNT_W-1:0]    rd_sel;
  logic [1:0]          state;

  // primed masks the first enabled cycle so stale history cannot look like an edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      probe_q    <= '0;
      probe_prev <= '0;
      primed     <= 1'b0;
    end else begin
      probe_q    <= probe;
      probe_prev <= probe_q;
      primed     <= enable;
    end
  end

  assign edge_vec = probe_q & ~probe_prev & {N_PROBES{primed}};

  for (genvar i = 0; i < N_PROBES; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (clear),
      .inc     (edge_vec[i] & enable),
      .cnt     (cnt[i]),
      .ovf     (cnt_ovf[i])
    );
  end

  assign edge_cnt  = (IDX_W+1)'(popcount(64'(edge_vec & {N_PROBES{enable}})));
  assign total_sum = {1'b0, total_cnt} + (TOT_W+1)'(edge_cnt);

  // The carry out of total_sum is exactly the "would exceed the ceiling" case.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      total_cnt <= '0;
      sat_flag  <= 1'b0;
    end else if (clear) begin
      total_cnt <= '0;
      sat_flag  <= 1'b0;
    end else begin
      total_cnt <= total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];
      if (total_sum[TOT_W] || (|cnt_ovf)) sat_flag <= 1'b1;
    end
  end

  // Indices past the last probe fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_PROBES; i++)
      if (rd.rd_idx == IDX_W'(i)) rd_sel = cnt[i];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      rd.rd_data <= '0;
    end else begin
      case (state)
        IDLE:    if (rd.rd_req) state <= CAPTURE;
        CAPTURE: begin
          rd.rd_data <= rd_sel;
          state      <= ACK;
        end
        ACK:     if (!rd.rd_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd.rd_ack = (state == ACK) && rd.rd_req;

endmodule

// File: tb/tb_pwr_transition_counter.sv
// Randomised and directed checks of pwr_transition_counter against a
// transition-level reference model (one 8-probe build, one 5-probe 4-bit build).
module tb_pwr_transition_counter;

  localparam int unsigned MAX_M_CNT = 65535;
  localparam int unsigned MAX_S_CNT = 15;
  localparam int unsigned MAX_M_TOT = 524287;
  localparam int unsigned MAX_S_TOT = 127;

  logic        clk;
  logic        reset_L;
  logic        enable;
  logic        clear;
  logic [7:0]  probe;
  logic [18:0] total_m;
  logic        sat_m;
  logic [6:0]  total_s;
  logic        sat_s;

  pwr_transition_counter_if #(.CNT_W(16), .IDX_W(3)) rif_m ();
  pwr_transition_counter_if #(.CNT_W(4),  .IDX_W(3)) rif_s ();

  pwr_transition_counter #(.N_PROBES(8), .CNT_W(16), .IDX_W(3), .TOT_W(19)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear), .probe(probe),
    .rd(rif_m), .total_cnt(total_m), .sat_flag(sat_m)
  );

  pwr_transition_counter #(.N_PROBES(5), .CNT_W(4), .IDX_W(3), .TOT_W(7)) dut_small (
    .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear), .probe(probe[4:0]),
    .rd(rif_s), .total_cnt(total_s), .sat_flag(sat_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counts rising transitions of the driven probe value.
  int unsigned m_cnt [8];
  int unsigned s_cnt [5];
  int unsigned m_tot, s_tot;
  bit          m_sat, s_sat;
  logic [7:0]  model_prev;
  int          n_vec, n_err;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    for (int i = 0; i < 5; i++) s_cnt[i] = 0;
    m_tot = 0; s_tot = 0; m_sat = 0; s_sat = 0;
  endtask

  task automatic model_apply(input logic [7:0] v);
    int unsigned nm, ns;
    nm = 0; ns = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && !model_prev[i]) begin
        nm++;
        if (m_cnt[i] == MAX_M_CNT) m_sat = 1; else m_cnt[i]++;
        if (i < 5) begin
          ns++;
          if (s_cnt[i] == MAX_S_CNT) s_sat = 1; else s_cnt[i]++;
        end
      end
    end
    if (m_tot + nm > MAX_M_TOT) begin m_tot = MAX_M_TOT; m_sat = 1; end else m_tot += nm;
    if (s_tot + ns > MAX_S_TOT) begin s_tot = MAX_S_TOT; s_sat = 1; end else s_tot += ns;
    model_prev = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_probe(input logic [7:0] v, input int hold);
    model_apply(v);
    probe = v;
    tick(hold);
  endtask

  // Enable is raised only after the sampling flops have caught up with probe.
  task automatic do_reset();
    enable = 0; clear = 0; reset_L = 0;
    rif_m.rd_req = 0; rif_s.rd_req = 0;
    tick(2);
    model_clear();
    model_prev = probe;
    reset_L = 1;
    tick(3);
    enable = 1;
    tick(2);
  endtask

  task automatic do_clear();
    tick(3);
    clear = 1;
    tick(1);
    clear = 0;
    model_clear();
    tick(1);
  endtask

  task automatic do_read(input bit sel, input logic [2:0] idx, output int lat,
                         output logic [15:0] data, output logic ack_after);
    lat = -1;
    if (sel) begin rif_s.rd_idx = idx; rif_s.rd_req = 1; end
    else     begin rif_m.rd_idx = idx; rif_m.rd_req = 1; end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((sel ? rif_s.rd_ack : rif_m.rd_ack) === 1'b1) begin lat = c; break; end
    end
    data = sel ? {12'b0, rif_s.rd_data} : rif_m.rd_data;
    if (sel) rif_s.rd_req = 0; else rif_m.rd_req = 0;
    #1;
    ack_after = sel ? rif_s.rd_ack : rif_m.rd_ack;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (total_m !== 19'd0) begin n_err++; $display("[TB] FAIL reset_total: got %0d expected 0", total_m); end
    n_vec++; if (sat_m !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sat: got %0b expected 0", sat_m); end
    n_vec++; if (rif_m.rd_ack !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ack: got %0b expected 0", rif_m.rd_ack); end
    n_vec++; if (rif_m.rd_data !== 16'd0) begin n_err++; $display("[TB] FAIL reset_data: got %0d expected 0", rif_m.rd_data); end
    n_vec++; if (total_s !== 7'd0) begin n_err++; $display("[TB] FAIL reset_total_small: got %0d expected 0", total_s); end
  endtask

  task automatic test_single_probe();
    int lat; logic [15:0] d; logic a;
    do_reset();
    for (int k = 0; k < 5; k++) begin drive_probe(8'h01, 2); drive_probe(8'h00, 2); end
    tick(3);
    do_read(0, 3'd0, lat, d, a);
    n_vec++; if (lat != 2) begin n_err++; $display("[TB] FAIL single_ack_latency: got %0d expected 2", lat); end
    n_vec++; if (d !== 16'(m_cnt[0])) begin n_err++; $display("[TB] FAIL single_rd_data: got %0d expected %0d", d, m_cnt[0]); end
    n_vec++; if (a !== 1'b0) begin n_err++; $display("[TB] FAIL single_ack_drop: got %0b expected 0", a); end
    n_vec++; if (total_m !== 19'(m_tot)) begin n_err++; $display("[TB] FAIL single_total: got %0d expected %0d", total_m, m_tot); end
  endtask

  task automatic test_primed();
    int lat; logic [15:0] d; logic a;
    probe = 8'hFF;
    do_reset();
    tick(4);
    n_vec++; if (total_m !== 19'(m_tot)) begin n_err++; $display("[TB] FAIL primed_total: got %0d expected %0d", total_m, m_tot); end
    n_vec++; if (total_s !== 7'(s_tot)) begin n_err++; $display("[TB] FAIL primed_total_small: got %0d expected %0d", total_s, s_tot); end
    do_read(0, 3'd7, lat, d, a);
    n_vec++; if (d !== 16'(m_cnt[7])) begin n_err++; $display("[TB] FAIL primed_rd_data: got %0d expected %0d", d, m_cnt[7]); end
    drive_probe(8'h00, 1);
    tick(3);
  endtask

  task automatic test_all_probes();
    int lat; logic [15:0] d; logic a;
    do_clear();
    for (int k = 0; k < 10; k++) begin drive_probe(8'hFF, 1); drive_probe(8'h00, 1); end
    tick(3);
    n_vec++; if (total_m !== 19'(m_tot)) begin n_err++; $display("[TB] FAIL all_total: got %0d expected %0d", total_m, m_tot); end
    n_vec++; if (total_s !== 7'(s_tot)) begin n_err++; $display("[TB] FAIL all_total_small: got %0d expected %0d", total_s, s_tot); end
    do_read(0, 3'd7, lat, d, a);
    n_vec++; if (d !== 16'(m_cnt[7])) begin n_err++; $display("[TB] FAIL all_rd7: got %0d expected %0d", d, m_cnt[7]); end
    do_read(1, 3'd4, lat, d, a);
    n_vec++; if (d !== 16'(s_cnt[4])) begin n_err++; $display("[TB] FAIL all_small_rd4: got %0d expected %0d", d, s_cnt[4]); end
    do_read(1, 3'd5, lat, d, a);
    n_vec++; if (d !== 16'd0) begin n_err++; $display("[TB] FAIL all_small_rd_out_of_range: got %0d expected 0", d); end
    n_vec++; if (sat_s !== s_sat) begin n_err++; $display("[TB] FAIL all_sat_small: got %0b expected %0b", sat_s, s_sat); end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] d; logic a;
    do_clear();
    for (int k = 0; k < 17; k++) begin drive_probe(8'h04, 1); drive_probe(8'h00, 1); end
    tick(3);
    do_read(1, 3'd2, lat, d, a);
    n_vec++; if (d !== 16'(s_cnt[2])) begin n_err++; $display("[TB] FAIL sat_cnt2: got %0d expected %0d", d, s_cnt[2]); end
    n_vec++; if (sat_s !== s_sat) begin n_err++; $display("[TB] FAIL sat_flag: got %0b expected %0b", sat_s, s_sat); end
    n_vec++; if (total_s !== 7'(s_tot)) begin n_err++; $display("[TB] FAIL sat_total: got %0d expected %0d", total_s, s_tot); end
    n_vec++; if (sat_m !== m_sat) begin n_err++; $display("[TB] FAIL sat_flag_wide: got %0b expected %0b", sat_m, m_sat); end
    // Clear spans the cycle in which the new edge reaches the counters.
    clear = 1; model_prev = 8'h04; probe = 8'h04;
    tick(2);
    clear = 0; model_clear();
    tick(3);
    do_read(1, 3'd2, lat, d, a);
    n_vec++; if (d !== 16'(s_cnt[2])) begin n_err++; $display("[TB] FAIL clr_cnt2: got %0d expected %0d", d, s_cnt[2]); end
    n_vec++; if (total_s !== 7'(s_tot)) begin n_err++; $display("[TB] FAIL clr_total: got %0d expected %0d", total_s, s_tot); end
    n_vec++; if (sat_s !== s_sat) begin n_err++; $display("[TB] FAIL clr_sat: got %0b expected %0b", sat_s, s_sat); end
    drive_probe(8'h00, 1);
    tick(3);
  endtask

  task automatic test_clear_during_ack();
    int lat; logic [15:0] d; logic a;
    int unsigned held;
    do_clear();
    for (int k = 0; k < 3; k++) begin drive_probe(8'h02, 1); drive_probe(8'h00, 1); end
    tick(3);
    held = m_cnt[1];
    rif_m.rd_idx = 3'd1; rif_m.rd_req = 1;
    tick(2);
    n_vec++; if (rif_m.rd_ack !== 1'b1) begin n_err++; $display("[TB] FAIL cda_ack: got %0b expected 1", rif_m.rd_ack); end
    clear = 1;
    tick(1);
    clear = 0; model_clear(); rif_m.rd_idx = 3'd0;
    tick(2);
    n_vec++; if (rif_m.rd_data !== 16'(held)) begin n_err++; $display("[TB] FAIL cda_held_data: got %0d expected %0d", rif_m.rd_data, held); end
    n_vec++; if (total_m !== 19'(m_tot)) begin n_err++; $display("[TB] FAIL cda_total: got %0d expected %0d", total_m, m_tot); end
    rif_m.rd_req = 0;
    #1;
    n_vec++; if (rif_m.rd_ack !== 1'b0) begin n_err++; $display("[TB] FAIL cda_ack_drop: got %0b expected 0", rif_m.rd_ack); end
    tick(2);
    do_read(0, 3'd1, lat, d, a);
    n_vec++; if (d !== 16'(m_cnt[1])) begin n_err++; $display("[TB] FAIL cda_reread: got %0d expected %0d", d, m_cnt[1]); end
  endtask

  task automatic test_reset_during_ack();
    int lat; logic [15:0] d; logic a;
    do_clear();
    for (int k = 0; k < 4; k++) begin drive_probe(8'h08, 1); drive_probe(8'h00, 1); end
    tick(3);
    rif_m.rd_idx = 3'd3; rif_m.rd_req = 1;
    tick(2);
    n_vec++; if (rif_m.rd_data !== 16'(m_cnt[3])) begin n_err++; $display("[TB] FAIL rda_data: got %0d expected %0d", rif_m.rd_data, m_cnt[3]); end
    #2 reset_L = 0;
    #1;
    n_vec++; if (rif_m.rd_ack !== 1'b0) begin n_err++; $display("[TB] FAIL rda_ack_async: got %0b expected 0", rif_m.rd_ack); end
    n_vec++; if (rif_m.rd_data !== 16'd0) begin n_err++; $display("[TB] FAIL rda_data_async: got %0d expected 0", rif_m.rd_data); end
    n_vec++; if (total_m !== 19'd0) begin n_err++; $display("[TB] FAIL rda_total_async: got %0d expected 0", total_m); end
    do_reset();
    for (int k = 0; k < 2; k++) begin drive_probe(8'h08, 1); drive_probe(8'h00, 1); end
    tick(3);
    do_read(0, 3'd3, lat, d, a);
    n_vec++; if (lat != 2) begin n_err++; $display("[TB] FAIL rda_new_latency: got %0d expected 2", lat); end
    n_vec++; if (d !== 16'(m_cnt[3])) begin n_err++; $display("[TB] FAIL rda_new_data: got %0d expected %0d", d, m_cnt[3]); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] d; logic a;
    logic [2:0] idx;
    logic [15:0] exp;
    do_clear();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 50; k++) drive_probe(8'($urandom), int'($urandom_range(1, 2)));
      tick(3);
      n_vec++; if (total_m !== 19'(m_tot)) begin n_err++; $display("[TB] FAIL rnd_total round %0d: got %0d expected %0d", r, total_m, m_tot); end
      n_vec++; if (total_s !== 7'(s_tot)) begin n_err++; $display("[TB] FAIL rnd_total_small round %0d: got %0d expected %0d", r, total_s, s_tot); end
      n_vec++; if (sat_m !== m_sat) begin n_err++; $display("[TB] FAIL rnd_sat round %0d: got %0b expected %0b", r, sat_m, m_sat); end
      n_vec++; if (sat_s !== s_sat) begin n_err++; $display("[TB] FAIL rnd_sat_small round %0d: got %0b expected %0b", r, sat_s, s_sat); end
      for (int i = 0; i < 8; i++) begin
        idx = 3'(i);
        do_read(0, idx, lat, d, a);
        n_vec++; if (d !== 16'(m_cnt[i])) begin n_err++; $display("[TB] FAIL rnd_rd idx %0d: got %0d expected %0d", i, d, m_cnt[i]); end
        do_read(1, idx, lat, d, a);
        exp = (i < 5) ? 16'(s_cnt[i]) : 16'd0;
        n_vec++; if (d !== exp) begin n_err++; $display("[TB] FAIL rnd_rd_small idx %0d: got %0d expected %0d", i, d, exp); end
      end
    end
  endtask

  initial begin
    reset_L = 0; enable = 0; clear = 0; probe = 8'h00;
    rif_m.rd_req = 0; rif_m.rd_idx = 3'd0;
    rif_s.rd_req = 0; rif_s.rd_idx = 3'd0;
    model_prev = 8'h00;
    n_vec = 0; n_err = 0;
    model_clear();
    $display("[TB] starting pwr_transition_counter bench");
    test_reset();
    test_single_probe();
    test_primed();
    test_all_probes();
    test_saturation();
    test_clear_during_ack();
    test_reset_during_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
